// File: rtl/tinker_pkg.sv
// Shared Tinker core definitions: register file geometry and command encodings.
package tinker_pkg;

    localparam int unsigned DATA_W   = 64;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned IDX_W    = $clog2(NUM_REGS);

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'b00,
        CMD_READ1 = 2'b01,
        CMD_READ2 = 2'b10,
        CMD_WRITE = 2'b11
    } cmd_e;

endpackage

// File: rtl/register_file.sv
// Tinker architectural register file: 32 x 64-bit registers, one command per cycle,
// read data returned through registered output latches one edge after the command.
module register_file
    import tinker_pkg::cmd_e;
    import tinker_pkg::CMD_READ1;
    import tinker_pkg::CMD_READ2;
    import tinker_pkg::CMD_WRITE;
#(
    parameter int unsigned DATA_W   = tinker_pkg::DATA_W,
    parameter int unsigned NUM_REGS = tinker_pkg::NUM_REGS,
    parameter int unsigned IDX_W    = tinker_pkg::IDX_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               control_signal,
    input  logic signed [DATA_W-1:0] input_port_1,
    input  logic signed [DATA_W-1:0] input_port_2,
    output logic signed [DATA_W-1:0] output_latch_1,
    output logic signed [DATA_W-1:0] output_latch_2
);

    cmd_e                cmd;
    logic [IDX_W-1:0]    idx_a;
    logic [IDX_W-1:0]    idx_b;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] reg_we;
    logic [DATA_W-1:0]   rd_a;
    logic [DATA_W-1:0]   rd_b;
    logic                unused_idx_bits;

    assign cmd   = cmd_e'(control_signal);
    // Only the low index bits address the array; upper bits alias onto it.
    assign idx_a = input_port_1[IDX_W-1:0];
    assign idx_b = input_port_2[IDX_W-1:0];
    assign unused_idx_bits = ^input_port_2[DATA_W-1:IDX_W];

    // Per-register write-enable decode from the write index.
    always_comb begin
        reg_we = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            reg_we[i] = (cmd == CMD_WRITE) && (idx_b == IDX_W'(i));
        end
    end

    // Register array storage, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (reg_we[i]) begin
                    regs[i] <= input_port_1;
                end
            end
        end
    end

    // Two independent read muxes.
    always_comb begin
        rd_a = regs[idx_a];
        rd_b = regs[idx_b];
    end

    // Output latches: A loads on read1/read2, B loads on read2 only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            output_latch_1 <= '0;
            output_latch_2 <= '0;
        end else begin
            if (cmd == CMD_READ1 || cmd == CMD_READ2) begin
                output_latch_1 <= rd_a;
            end
            if (cmd == CMD_READ2) begin
                output_latch_2 <= rd_b;
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: vector table plus reset corner sequences,
// expected latch values flow through a scoreboard queue.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic [1:0]  control_signal;
    logic [63:0] input_port_1;
    logic [63:0] input_port_2;
    logic [63:0] output_latch_1;
    logic [63:0] output_latch_2;

    int total;
    int bad;

    typedef struct {
        logic [63:0] e1;
        logic [63:0] e2;
    } exp_t;

    typedef struct {
        logic [1:0]  cmd;
        logic [63:0] p1;
        logic [63:0] p2;
        logic [63:0] e1;
        logic [63:0] e2;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[20];

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] READ1 = 2'b01;
    localparam logic [1:0] READ2 = 2'b10;
    localparam logic [1:0] WRITE = 2'b11;

    localparam logic [63:0] PAT  = 64'hDB6D_B6DB_6DB6_DB6D;
    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

    register_file #(.DATA_W(64), .NUM_REGS(32), .IDX_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .control_signal (control_signal),
        .input_port_1   (input_port_1),
        .input_port_2   (input_port_2),
        .output_latch_1 (output_latch_1),
        .output_latch_2 (output_latch_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_pop(input string nm);
        exp_t e;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty, got o1=%h o2=%h", nm, output_latch_1, output_latch_2);
        end else begin
            e = sb_q.pop_front();
            if (output_latch_1 !== e.e1 || output_latch_2 !== e.e2) begin
                bad++;
                $display("FAIL %s: got o1=%h o2=%h want o1=%h o2=%h",
                         nm, output_latch_1, output_latch_2, e.e1, e.e2);
            end
        end
    endtask

    task automatic step(input logic [1:0] c, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] e1, input logic [63:0] e2, input string nm);
        @(negedge clk);
        control_signal = c;
        input_port_1   = a;
        input_port_2   = b;
        sb_q.push_back('{e1: e1, e2: e2});
        @(posedge clk);
        #1;
        check_pop(nm);
    endtask

    initial begin
        vecs[0]  = '{cmd: READ2, p1: 64'd5,  p2: 64'd31, e1: 64'd0,    e2: 64'd0};
        vecs[1]  = '{cmd: WRITE, p1: PAT,    p2: 64'd1,  e1: 64'd0,    e2: 64'd0};
        vecs[2]  = '{cmd: READ1, p1: 64'd1,  p2: 64'd0,  e1: PAT,      e2: 64'd0};
        vecs[3]  = '{cmd: WRITE, p1: MAXP,   p2: 64'd3,  e1: PAT,      e2: 64'd0};
        vecs[4]  = '{cmd: WRITE, p1: MINN,   p2: 64'd30, e1: PAT,      e2: 64'd0};
        vecs[5]  = '{cmd: READ2, p1: 64'd3,  p2: 64'd30, e1: MAXP,     e2: MINN};
        vecs[6]  = '{cmd: WRITE, p1: 64'h1234, p2: 64'd33, e1: MAXP,   e2: MINN};
        vecs[7]  = '{cmd: READ1, p1: 64'd1,  p2: 64'd30, e1: 64'h1234, e2: MINN};
        vecs[8]  = '{cmd: READ1, p1: 64'd65, p2: 64'd0,  e1: 64'h1234, e2: MINN};
        vecs[9]  = '{cmd: WRITE, p1: 64'd1,  p2: 64'd7,  e1: 64'h1234, e2: MINN};
        vecs[10] = '{cmd: WRITE, p1: 64'd2,  p2: 64'd7,  e1: 64'h1234, e2: MINN};
        vecs[11] = '{cmd: READ1, p1: 64'd7,  p2: 64'd0,  e1: 64'd2,    e2: MINN};
        vecs[12] = '{cmd: IDLE,  p1: 64'd3,  p2: 64'd1,  e1: 64'd2,    e2: MINN};
        vecs[13] = '{cmd: IDLE,  p1: 64'd30, p2: 64'd3,  e1: 64'd2,    e2: MINN};
        vecs[14] = '{cmd: IDLE,  p1: 64'd1,  p2: 64'd30, e1: 64'd2,    e2: MINN};
        vecs[15] = '{cmd: WRITE, p1: 64'hAAAA_5555_AAAA_5555, p2: 64'd0, e1: 64'd2, e2: MINN};
        vecs[16] = '{cmd: READ2, p1: 64'd0,  p2: 64'd0,  e1: 64'hAAAA_5555_AAAA_5555,
                     e2: 64'hAAAA_5555_AAAA_5555};
        vecs[17] = '{cmd: READ2, p1: 64'hFFFF_FFFF_FFFF_FFE3, p2: 64'd7, e1: MAXP, e2: 64'd2};
        vecs[18] = '{cmd: READ1, p1: 64'd1,  p2: 64'd3,  e1: 64'h1234, e2: 64'd2};
        vecs[19] = '{cmd: READ2, p1: 64'd30, p2: 64'd1,  e1: MINN,     e2: 64'h1234};

        total = 0;
        bad   = 0;
        rst            = 1'b1;
        control_signal = IDLE;
        input_port_1   = '0;
        input_port_2   = '0;

        // Outputs are cleared while reset is held.
        @(posedge clk);
        #1;
        sb_q.push_back('{e1: 64'd0, e2: 64'd0});
        check_pop("reset_state");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            step(vecs[i].cmd, vecs[i].p1, vecs[i].p2, vecs[i].e1, vecs[i].e2,
                 $sformatf("vec%0d", i));
        end

        // Asynchronous reset pulse between edges clears outputs without a clock.
        @(negedge clk);
        control_signal = IDLE;
        #1;
        rst = 1'b1;
        #1;
        sb_q.push_back('{e1: 64'd0, e2: 64'd0});
        check_pop("async_reset_outputs");
        rst = 1'b0;
        step(READ2, 64'd3, 64'd1, 64'd0, 64'd0, "post_reset_read2");
        step(READ2, 64'd5, 64'd31, 64'd0, 64'd0, "post_reset_read2_5_31");

        // Reset while a write is being held.
        step(WRITE, 64'd5, 64'd9, 64'd0, 64'd0, "write_r9");
        step(READ1, 64'd9, 64'd0, 64'd5, 64'd0, "read_r9_before_reset");
        step(WRITE, 64'd5, 64'd9, 64'd5, 64'd0, "hold_write_r9");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        sb_q.push_back('{e1: 64'd0, e2: 64'd0});
        check_pop("midop_reset_outputs");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        control_signal = READ1;
        input_port_1   = 64'd9;
        sb_q.push_back('{e1: 64'd0, e2: 64'd0});
        @(posedge clk);
        #1;
        check_pop("midop_reset_read_r9");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
